// File: rtl/fft_bundle_seq_if.sv
// rtl/fft_bundle_seq_if.sv - handshake bundle between bundle source, sequencer and sink
interface fft_bundle_seq_if #(
  parameter int IDX_W = 5
) ();
  logic             in_valid;
  logic             in_sof;
  logic             in_ready;
  logic             bf_en;
  logic [IDX_W-1:0] bundle_idx;
  logic             out_valid;
  logic             out_sof;
  logic             out_eof;
  logic             out_ready;

  modport master (
    output in_valid, in_sof, out_ready,
    input  in_ready, bf_en, bundle_idx, out_valid, out_sof, out_eof
  );

  modport slave (
    input  in_valid, in_sof, out_ready,
    output in_ready, bf_en, bundle_idx, out_valid, out_sof, out_eof
  );
endinterface

// File: rtl/fft_bundle_seq.sv
// rtl/fft_bundle_seq.sv - radix-2^2 bundle sequencer; optional FFT_SEQ_STATS_EN adds frame/drop counters
module fft_bundle_seq #(
  parameter int N_BUNDLE = 32,
  parameter int LAT      = 1,
  parameter int IDX_W    = $clog2(N_BUNDLE)
) (
  input  logic              clk,
  input  logic              rst_n,
  fft_bundle_seq_if.slave   bus,
  output logic              frame_err,
  input  logic              clr_err
`ifdef FFT_SEQ_STATS_EN
  ,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       drop_cnt
`endif
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BUNDLE - 1);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] cnt, cnt_nxt;
  logic [LAT-1:0]   tag_v, tag_sof, tag_eof;
  logic             advance, acc;
  logic             push_v, push_sof, push_eof, err_set;

  // The whole pipe moves whenever the output slot is empty or being drained.
  assign advance      = !tag_v[LAT-1] || bus.out_ready;
  assign bus.bf_en    = rst_n & advance;
  assign bus.in_ready = rst_n & advance;
  assign acc          = bus.in_valid & bus.in_ready;

  assign bus.out_valid = tag_v[LAT-1];
  assign bus.out_sof   = tag_sof[LAT-1];
  assign bus.out_eof   = tag_eof[LAT-1];

  // Frame state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Framing decisions: what enters the pipe, where we are in the frame, error detection.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    push_v         = 1'b0;
    push_sof       = 1'b0;
    push_eof       = 1'b0;
    err_set        = 1'b0;
    bus.bundle_idx = '0;
    case (state)
      IDLE: begin
        if (acc) begin
          if (bus.in_sof) begin
            push_v    = 1'b1;
            push_sof  = 1'b1;
            cnt_nxt   = ONE_IDX;
            state_nxt = RUN;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      RUN: begin
        bus.bundle_idx = (bus.in_valid && bus.in_sof) ? '0 : cnt;
        if (acc) begin
          push_v = 1'b1;
          if (bus.in_sof) begin
            // Premature start: resync onto the new frame, old frame never gets eof.
            err_set  = 1'b1;
            push_sof = 1'b1;
            cnt_nxt  = ONE_IDX;
          end else if (cnt == LAST_IDX) begin
            push_eof  = 1'b1;
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt + ONE_IDX;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Tag pipeline tracks the datapath stage by stage; bubbles carry v=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v   <= '0;
      tag_sof <= '0;
      tag_eof <= '0;
    end else if (advance) begin
      for (int k = LAT - 1; k > 0; k--) begin
        tag_v[k]   <= tag_v[k-1];
        tag_sof[k] <= tag_sof[k-1];
        tag_eof[k] <= tag_eof[k-1];
      end
      tag_v[0]   <= push_v;
      tag_sof[0] <= push_sof;
      tag_eof[0] <= push_eof;
    end
  end

  // Sticky framing error; a new error outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       frame_err <= 1'b0;
    else if (err_set) frame_err <= 1'b1;
    else if (clr_err) frame_err <= 1'b0;
  end

`ifdef FFT_SEQ_STATS_EN
  logic frame_done, drop_hit;
  assign frame_done = bus.out_valid & bus.out_ready & bus.out_eof;
  assign drop_hit   = (state == IDLE) & acc & !bus.in_sof;

  // Saturating statistics counters, cleared together with the error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else if (clr_err) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (frame_done && frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
      if (drop_hit && drop_cnt != 16'hFFFF)    drop_cnt  <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule
